// File: rtl/systolic_mac_pe_if.sv
// Handshake/operand bundle for one systolic MAC processing element.
// The master drives operands and acknowledges results; the PE is the slave.
interface systolic_mac_pe_if #(
    parameter int ACT_W = 16,
    parameter int WGT_W = 8,
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
);
    logic             clear;
    logic [CNT_W-1:0] k_len;
    logic             in_valid;
    logic             in_ready;
    logic [ACT_W-1:0] a_in;
    logic [WGT_W-1:0] w_in;
    logic [ACT_W-1:0] a_out;
    logic [WGT_W-1:0] w_out;
    logic             fwd_valid;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_sat;
    logic             busy;

    modport master (
        output clear, k_len, in_valid, a_in, w_in, res_ready,
        input  in_ready, a_out, w_out, fwd_valid, res_valid, res_data, res_sat, busy
    );

    modport slave (
        input  clear, k_len, in_valid, a_in, w_in, res_ready,
        output in_ready, a_out, w_out, fwd_valid, res_valid, res_data, res_sat, busy
    );
endinterface

// File: rtl/systolic_mac_pe.sv
// Systolic MAC PE: 2-stage multiply/accumulate over k_len beats with a
// saturating accumulator, operand forwarding and a held result handshake.
module systolic_mac_pe #(
    parameter int ACT_W  = 16,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 16,
    parameter bit SIGNED = 1'b1
) (
    input logic             clk,
    input logic             rstn,
    systolic_mac_pe_if.slave bus
);
    localparam int PW = ACT_W + WGT_W;

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_klen;
    logic [1:0]       r_vld_pipe;
    logic [1:0]       r_last_pipe;
    logic [ACT_W-1:0] r_a;
    logic [WGT_W-1:0] r_w;
    logic [PW-1:0]    r_prod;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic             r_res_valid;

    logic             w_accept;
    logic [CNT_W-1:0] w_k_eff;
    logic             w_last;
    logic [PW-1:0]    w_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_sat_val;
    logic [ACC_W-1:0] w_acc_nxt;

    assign bus.in_ready  = (r_state == IDLE) || (r_state == ACC);
    assign bus.busy      = (r_state != IDLE);
    assign bus.a_out     = r_a;
    assign bus.w_out     = r_w;
    assign bus.fwd_valid = r_vld_pipe[0];
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_acc;
    assign bus.res_sat   = r_sat;

    // clear wins over a simultaneous beat
    assign w_accept = bus.in_valid && bus.in_ready && !bus.clear;
    assign w_k_eff  = (bus.k_len == '0) ? CNT_W'(1) : bus.k_len;
    assign w_last   = (r_state == IDLE) ? (w_k_eff == CNT_W'(1))
                                        : (r_cnt + CNT_W'(1) == r_klen);

    generate
        if (SIGNED) begin : g_signed
            assign w_prod     = PW'($signed(r_a)) * PW'($signed(r_w));
            assign w_prod_ext = ACC_W'($signed(r_prod));
            assign w_sum      = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
            assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
            // the extra top bit is the true sign, so it picks the rail
            assign w_sat_val  = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                             : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin : g_unsigned
            assign w_prod     = PW'(r_a) * PW'(r_w);
            assign w_prod_ext = ACC_W'(r_prod);
            assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
            assign w_ovf      = w_sum[ACC_W];
            assign w_sat_val  = '1;
        end
    endgenerate

    assign w_acc_nxt = w_ovf ? w_sat_val : w_sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_klen      <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_a         <= '0;
            r_w         <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (bus.clear) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_klen      <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[0], w_accept};
            r_last_pipe <= {r_last_pipe[0], w_accept && w_last};
            if (w_accept) begin
                r_a <= bus.a_in;
                r_w <= bus.w_in;
            end
            if (r_vld_pipe[0]) r_prod <= w_prod;
            if (r_vld_pipe[1]) begin
                r_acc <= w_acc_nxt;
                if (w_ovf) r_sat <= 1'b1;
            end

            case (r_state)
                IDLE: if (w_accept) begin
                    r_klen  <= w_k_eff;
                    r_cnt   <= CNT_W'(1);
                    r_state <= w_last ? DRAIN : ACC;
                end
                ACC: if (w_accept) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) r_state <= DRAIN;
                end
                DRAIN: if (r_vld_pipe[1] && r_last_pipe[1]) begin
                    r_state     <= HOLD;
                    r_res_valid <= 1'b1;
                end
                HOLD: if (bus.res_ready) begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_acc       <= '0;
                    r_sat       <= 1'b0;
                    r_cnt       <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/systolic_mac_pe.md
SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

Interface
REQ-001 SHALL have parameter ACT_W, default 16: activation width.
REQ-002 SHALL have parameter WGT_W, default 8: weight width.
REQ-003 SHALL have parameter ACC_W, default 40: accumulator/result width, ACC_W >= ACT_W+WGT_W.
REQ-004 SHALL have parameter CNT_W, default 16: width of the dot-product length.
REQ-005 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have port clk, input, 1: clock, rising edge.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port clear, input, 1: synchronous abort/flush.
REQ-009 SHALL have port k_len, input, CNT_W: beats per dot product, sampled on the first beat.
REQ-010 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input beat handshake.
REQ-011 SHALL have ports a_in (input, ACT_W) and w_in (input, WGT_W): operands.
REQ-012 SHALL have ports a_out (output, ACT_W), w_out (output, WGT_W) and fwd_valid (output, 1): systolic forwarding to neighbour PEs.
REQ-013 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, ACC_W) and res_sat (output, 1): result handshake and sticky saturation flag.
REQ-014 SHALL have port busy, output, 1: high whenever state != IDLE.

Function
REQ-015 SHALL accept a beat only when in_valid && in_ready; in_ready = 1 in IDLE and ACC, 0 in DRAIN and HOLD.
REQ-016 SHALL implement states IDLE, ACC, DRAIN, HOLD: IDLE->ACC on the first accepted beat when k_len > 1; IDLE/ACC->DRAIN on the accepted beat that completes k_len beats; DRAIN->HOLD when the final product is accumulated; HOLD->IDLE on res_valid && res_ready.
REQ-017 SHALL treat k_len == 0 as 1; k_len changes after the first beat SHALL be ignored until the next IDLE.
REQ-018 SHALL pipeline in 2 stages: product register loaded at edge t+1, accumulator updated at edge t+2, for a beat accepted at edge t.
REQ-019 SHALL compute the product at full ACT_W+WGT_W width, sign- or zero-extended to ACC_W per SIGNED.
REQ-020 SHALL saturate the accumulator to the ACC_W max/min (signed) or 2^ACC_W-1 (unsigned) on overflow, and SHALL set res_sat, sticky until the result handshake.
REQ-021 SHALL assert res_valid at the edge the final accumulate completes (t+2 after the last beat), holding res_data and res_sat stable until res_ready.
REQ-022 SHALL clear the accumulator, res_sat and the beat counter on the HOLD->IDLE transition; with res_ready already high, res_valid SHALL be high for exactly 1 cycle.
REQ-023 SHALL register a_out/w_out with accepted a_in/w_in, fwd_valid = 1 the cycle after each accepted beat, otherwise 0, and a_out/w_out holding their last value.
REQ-024 SHALL give clear priority over all other inputs: at the next edge state = IDLE, pipeline/accumulator/counter/res_sat flushed, res_valid = 0, fwd_valid = 0, and no beat accepted in that cycle.

Reset
REQ-025 SHALL, while rstn = 0, force state IDLE, accumulator, product register, counter, res_data, a_out, w_out = 0, res_valid, res_sat, fwd_valid, busy = 0, in_ready = 1 after release.
REQ-026 SHALL, on reset mid-operation, discard the partial sum, and the first beat after release SHALL start a new dot product.

Verification
REQ-027 SHALL check: SIGNED=1, k_len=4, a={1,2,3,4}, w={1,1,1,1} back-to-back -> res_valid 2 cycles after the 4th beat, res_data=10, res_sat=0.
REQ-028 SHALL check: SIGNED=1, k_len=2, a=-3 (0xFFFD), w=5 then a=2, w=-1 -> res_data = -17 sign-extended to 40 bits.
REQ-029 SHALL check: ACC_W=24, SIGNED=1, k_len=300, a=32767, w=127 -> res_data = 0x7FFFFF, res_sat=1.
REQ-030 SHALL check: res_ready=0 for 5 cycles in HOLD -> res_valid/res_data stable, in_ready=0, in_valid beats not accepted; res_ready=1 -> IDLE next cycle.
REQ-031 SHALL check: clear asserted on beat 2 of k_len=4, then a new k_len=1, a=7, w=3 -> res_data=21, no residue from the aborted sum.
REQ-032 SHALL check: rstn pulsed low mid-ACC -> all outputs at reset values asynchronously; a_out/w_out/fwd_valid track accepted beats with 1-cycle latency afterwards.
